// File: rtl/float_lt_axis_core.sv
// Two-stage AXI-Stream IEEE-754 single-precision "A < B" comparator.
// Stage1 registers the operand classification; stage2 is the result output register.
module float_lt_axis_core #(
    parameter logic NAN_RESULT   = 1'b0,
    parameter logic FLUSH_DENORM = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce,
    input  logic [31:0] s_axis_a_tdata,
    input  logic        s_axis_a_tvalid,
    output logic        s_axis_a_tready,
    input  logic [31:0] s_axis_b_tdata,
    input  logic        s_axis_b_tvalid,
    output logic        s_axis_b_tready,
    output logic [7:0]  m_axis_result_tdata,
    output logic        m_axis_result_tvalid,
    input  logic        m_axis_result_tready
);

    typedef struct packed {
        logic nan;
        logic both_zero;
        logic sign_a;
        logic sign_b;
        logic mag_lt;
        logic mag_gt;
    } class_t;

    class_t      cls_d;
    class_t      s1_cls;
    logic        s1_valid;
    logic        lt_s1;
    logic        s2_room;
    logic        s1_room;
    logic        accept;
    logic        a_nan;
    logic        b_nan;
    logic        a_zero;
    logic        b_zero;
    logic [30:0] a_mag;
    logic [30:0] b_mag;

    // Subnormals count as zero only when flushing; a flushed zero keeps its sign.
    assign a_nan  = (&s_axis_a_tdata[30:23]) && (|s_axis_a_tdata[22:0]);
    assign b_nan  = (&s_axis_b_tdata[30:23]) && (|s_axis_b_tdata[22:0]);
    assign a_zero = (s_axis_a_tdata[30:23] == 8'd0) && (FLUSH_DENORM || s_axis_a_tdata[22:0] == 23'd0);
    assign b_zero = (s_axis_b_tdata[30:23] == 8'd0) && (FLUSH_DENORM || s_axis_b_tdata[22:0] == 23'd0);
    assign a_mag  = a_zero ? 31'd0 : s_axis_a_tdata[30:0];
    assign b_mag  = b_zero ? 31'd0 : s_axis_b_tdata[30:0];

    assign cls_d.nan       = a_nan || b_nan;
    assign cls_d.both_zero = a_zero && b_zero;
    assign cls_d.sign_a    = s_axis_a_tdata[31];
    assign cls_d.sign_b    = s_axis_b_tdata[31];
    assign cls_d.mag_lt    = a_mag < b_mag;
    assign cls_d.mag_gt    = a_mag > b_mag;

    // Stage1 may take a new beat if it is empty or its contents move on this edge.
    assign s2_room = !m_axis_result_tvalid || m_axis_result_tready;
    assign s1_room = !s1_valid || s2_room;

    assign s_axis_a_tready = ce && rst_n && s1_room;
    assign s_axis_b_tready = s_axis_a_tready;
    assign accept          = s_axis_a_tready && s_axis_a_tvalid && s_axis_b_tvalid;

    always_comb begin
        // NOTE: default assignment first so every path drives lt_s1 and no latch is inferred.
        lt_s1 = 1'b0;
        if (s1_cls.nan)
            lt_s1 = NAN_RESULT;
        else if (s1_cls.both_zero)
            lt_s1 = 1'b0;
        else if (s1_cls.sign_a != s1_cls.sign_b)
            lt_s1 = s1_cls.sign_a;
        else if (s1_cls.sign_a)
            lt_s1 = s1_cls.mag_gt;
        else
            lt_s1 = s1_cls.mag_lt;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid             <= 1'b0;
            m_axis_result_tvalid <= 1'b0;
            m_axis_result_tdata  <= 8'h00;
        end else if (ce) begin
            if (s2_room) begin
                m_axis_result_tvalid <= s1_valid;
                if (s1_valid)
                    m_axis_result_tdata <= {7'd0, lt_s1};
            end
            if (s1_room)
                s1_valid <= accept;
        end
    end

    // NOTE: payload needs no reset; it is only observed when s1_valid is set.
    always_ff @(posedge clk) begin
        if (accept)
            s1_cls <= cls_d;
    end

endmodule

// File: tb/tb_float_lt_axis_core.sv
// Self-checking bench for float_lt_axis_core: directed literal vectors plus a
// scoreboard fed by a sign-magnitude ordering model, run on two parameter sets.
module tb_float_lt_axis_core;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ce;
    logic [31:0] a_data;
    logic [31:0] b_data;
    logic        a_valid;
    logic        b_valid;
    logic        m_ready;
    logic        a_rdy   [2];
    logic        b_rdy   [2];
    logic [7:0]  r_data  [2];
    logic        r_valid [2];

    int n_cmp = 0;
    int n_bad = 0;
    int retired [2];

    bit          exp_q     [2][$];
    bit          prev_hold [2];
    logic [7:0]  prev_data [2];

    always #5 clk = ~clk;

    float_lt_axis_core #(.NAN_RESULT(1'b0), .FLUSH_DENORM(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .ce(ce),
        .s_axis_a_tdata(a_data), .s_axis_a_tvalid(a_valid), .s_axis_a_tready(a_rdy[0]),
        .s_axis_b_tdata(b_data), .s_axis_b_tvalid(b_valid), .s_axis_b_tready(b_rdy[0]),
        .m_axis_result_tdata(r_data[0]), .m_axis_result_tvalid(r_valid[0]),
        .m_axis_result_tready(m_ready)
    );

    float_lt_axis_core #(.NAN_RESULT(1'b1), .FLUSH_DENORM(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .ce(ce),
        .s_axis_a_tdata(a_data), .s_axis_a_tvalid(a_valid), .s_axis_a_tready(a_rdy[1]),
        .s_axis_b_tdata(b_data), .s_axis_b_tvalid(b_valid), .s_axis_b_tready(b_rdy[1]),
        .m_axis_result_tdata(r_data[1]), .m_axis_result_tvalid(r_valid[1]),
        .m_axis_result_tready(m_ready)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic bit is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    // Non-NaN floats order like signed integers of sign * magnitude; both zeros map to 0.
    function automatic int order_key(input logic [31:0] x, input bit flush);
        int mag;
        mag = (flush && x[30:23] == 8'd0) ? 0 : int'({1'b0, x[30:0]});
        return x[31] ? -mag : mag;
    endfunction

    function automatic bit model_lt(input logic [31:0] a, input logic [31:0] b,
                                    input bit nan_res, input bit flush);
        if (is_nan(a) || is_nan(b))
            return nan_res;
        return order_key(a, flush) < order_key(b, flush);
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] specials [8];
        specials = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
                     32'h7FC00000, 32'h00000001, 32'h3F800000, 32'hBF800000};
        if ($urandom_range(0, 7) < 5)
            return $urandom;
        return specials[$urandom_range(0, 7)];
    endfunction

    // Scoreboard: predicts the handshakes of the coming edge and checks every retired result.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                check($sformatf("rst_tready%0d", d), {a_rdy[d], b_rdy[d]}, 2'b00);
                exp_q[d].delete();
                prev_hold[d] = 1'b0;
            end else begin
                check($sformatf("tready_a%0d", d), a_rdy[d], ce && (exp_q[d].size() < 2 || m_ready));
                check($sformatf("tready_b%0d", d), b_rdy[d], ce && (exp_q[d].size() < 2 || m_ready));
                if (exp_q[d].size() == 0)
                    check($sformatf("idle_tvalid%0d", d), r_valid[d], 1'b0);
                if (prev_hold[d]) begin
                    check($sformatf("hold_tvalid%0d", d), r_valid[d], 1'b1);
                    check($sformatf("hold_tdata%0d", d), r_data[d], prev_data[d]);
                end
                if (r_valid[d] && m_ready && ce) begin
                    if (exp_q[d].size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL extra_result%0d: got %h, expected no result", d, r_data[d]);
                    end else begin
                        check($sformatf("result%0d", d), r_data[d], {7'd0, exp_q[d].pop_front()});
                        retired[d]++;
                    end
                end
                if (a_rdy[d] && a_valid && b_valid)
                    exp_q[d].push_back(model_lt(a_data, b_data, d[0], d[0]));
                prev_hold[d] = r_valid[d] && (!m_ready || !ce);
                prev_data[d] = r_data[d];
            end
        end
    end

    // One beat on an empty pipeline with literal expectations for both parameter sets.
    task automatic directed(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic [7:0] e0, input logic [7:0] e1);
        @(posedge clk); #1;
        a_data = a; b_data = b; a_valid = 1'b1; b_valid = 1'b1; m_ready = 1'b1; ce = 1'b1;
        @(posedge clk); #1;
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk);
        check({name, "_lat0"}, r_valid[0], 1'b0);
        check({name, "_lat1"}, r_valid[1], 1'b0);
        @(posedge clk); #1;
        check({name, "_valid0"}, r_valid[0], 1'b1);
        check({name, "_valid1"}, r_valid[1], 1'b1);
        check({name, "_data0"}, r_data[0], e0);
        check({name, "_data1"}, r_data[1], e1);
        check({name, "_model0"}, model_lt(a, b, 1'b0, 1'b0), e0[0]);
        check({name, "_model1"}, model_lt(a, b, 1'b1, 1'b1), e1[0]);
        @(posedge clk);
    endtask

    initial begin
        int  sent;
        int  cyc;
        bit  acc;

        rst_n = 1'b0; ce = 1'b1; a_valid = 1'b0; b_valid = 1'b0; m_ready = 1'b1;
        a_data = 32'd0; b_data = 32'd0;
        retired[0] = 0; retired[1] = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset_tvalid%0d", d), r_valid[d], 1'b0);
            check($sformatf("reset_tdata%0d", d), r_data[d], 8'h00);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_tready", a_rdy[0], 1'b1);

        directed("one_lt_two",  32'h3F800000, 32'h40000000, 8'h01, 8'h01);
        directed("two_lt_one",  32'h40000000, 32'h3F800000, 8'h00, 8'h00);
        directed("negz_posz",   32'h80000000, 32'h00000000, 8'h00, 8'h00);
        directed("nan_one",     32'h7FC00000, 32'h3F800000, 8'h00, 8'h01);
        directed("denorm",      32'h00000001, 32'h00000002, 8'h01, 8'h00);
        directed("neginf",      32'hFF800000, 32'hFF7FFFFF, 8'h01, 8'h01);

        // 100 random beats back to back, output stalled for 5 cycles mid-stream.
        retired[0] = 0; retired[1] = 0;
        sent = 0; cyc = 0;
        @(posedge clk); #1;
        a_data = rand_word(); b_data = rand_word(); a_valid = 1'b1; b_valid = 1'b1;
        while (sent < 100 && cyc < 2000) begin
            m_ready = !(cyc >= 30 && cyc < 35);
            @(negedge clk);
            acc = a_rdy[0] && a_valid && b_valid;
            if (cyc == 33)
                check("stall_full_tready", a_rdy[0], 1'b0);
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                sent++;
                if (sent < 100) begin
                    a_data = rand_word(); b_data = rand_word();
                end else begin
                    a_valid = 1'b0; b_valid = 1'b0;
                end
            end
        end
        check("stream_sent", sent, 100);
        m_ready = 1'b1;
        cyc = 0;
        while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("stream_retired0", retired[0], 100);
        check("stream_retired1", retired[1], 100);

        // Lone A beat must never be consumed.
        @(posedge clk); #1;
        a_data = 32'h3F800000; b_data = 32'h40000000; a_valid = 1'b1; b_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("lone_a_tvalid", r_valid[0], 1'b0);
            check("lone_a_tready", a_rdy[0], 1'b1);
        end
        @(posedge clk); #1;
        a_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("lone_a_after", r_valid[0], 1'b0);
        end

        // Freeze a pending result with ce low.
        @(posedge clk); #1;
        m_ready = 1'b0; a_valid = 1'b1; b_valid = 1'b1;
        @(posedge clk); #1;
        a_valid = 1'b0; b_valid = 1'b0;
        @(posedge clk); #1;
        ce = 1'b0; m_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("ce_tvalid", r_valid[0], 1'b1);
            check("ce_tdata", r_data[0], 8'h01);
            check("ce_tready", a_rdy[0], 1'b0);
        end
        @(posedge clk); #1;
        ce = 1'b1;
        check("ce_not_retired", r_valid[0], 1'b1);
        @(posedge clk); #1;
        check("ce_retired", r_valid[0], 1'b0);

        // Fill both stages, then reset for one edge.
        m_ready = 1'b0;
        a_data = 32'h40000000; b_data = 32'h3F800000; a_valid = 1'b1; b_valid = 1'b1;
        @(posedge clk); #1;
        a_data = 32'hC0400000; b_data = 32'h40A00000;
        @(posedge clk); #1;
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk);
        check("full_tready", a_rdy[0], 1'b0);
        check("full_tvalid", r_valid[0], 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("midrst_tvalid%0d", d), r_valid[d], 1'b0);
            check($sformatf("midrst_tdata%0d", d), r_data[d], 8'h00);
        end
        m_ready = 1'b1;
        @(negedge clk);
        check("midrst_tready", a_rdy[0], 1'b1);
        repeat (3) begin
            @(negedge clk);
            check("no_stale0", r_valid[0], 1'b0);
            check("no_stale1", r_valid[1], 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
